// File: rtl/mm_controller.sv
`default_nettype none
// ============================================================================
// Module   : mm_controller
// Purpose  : Address and strobe sequencer for the data_path MAC computing
//            C[MxP] = A[MxN] x B[NxP] from row-major synchronous memories.
// Revision : 1.0 - initial release
// ============================================================================
module mm_controller #(
  parameter int M          = 2,
  parameter int N          = 2,
  parameter int P          = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  resultIsInvalid,
  output logic [ADDR_WIDTH-1:0] addr_A,
  output logic [ADDR_WIDTH-1:0] addr_B,
  output logic                  en_Mux,
  output logic                  en_PPReg,
  output logic                  en_FDReg,
  output logic [ADDR_WIDTH-1:0] addr_C,
  output logic                  writeEn_C,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] c_one    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_n      = ADDR_WIDTH'(N);
  localparam logic [ADDR_WIDTH-1:0] c_p      = ADDR_WIDTH'(P);
  localparam logic [ADDR_WIDTH-1:0] c_m_last = ADDR_WIDTH'(M - 1);
  localparam logic [ADDR_WIDTH-1:0] c_n_last = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] c_p_last = ADDR_WIDTH'(P - 1);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [ADDR_WIDTH-1:0] r_i, r_j, r_k;
  logic [ADDR_WIDTH-1:0] w_i_nxt, w_j_nxt, w_k_nxt;
  logic                  w_last_i, w_last_j, w_last_k, w_last;
  logic                  r_drain;
  logic [ADDR_WIDTH-1:0] r_addr_c_pipe;

  logic                  w_accept, w_advance;
  logic [ADDR_WIDTH-1:0] w_addr_a_d, w_addr_b_d, w_addr_c_pipe_d;
  logic                  w_en_pp_d, w_en_mux_d, w_en_fd_d;
  logic                  w_busy_d, w_done_d, w_error_d;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start)   w_next_state = S_ISSUE;
      S_ISSUE: if (w_last)  w_next_state = S_DRAIN;
      S_DRAIN: if (r_drain) w_next_state = S_DONE;
      S_DONE:               w_next_state = S_IDLE;
      default:              w_next_state = S_IDLE;
    endcase
  end

  // (i,j,k) is the triple whose address is currently on addr_A/addr_B; k fastest
  always_comb begin
    w_last_k = (r_k == c_n_last);
    w_last_j = (r_j == c_p_last);
    w_last_i = (r_i == c_m_last);
    w_last   = w_last_i && w_last_j && w_last_k;
    w_k_nxt  = w_last_k ? '0 : r_k + c_one;
    w_j_nxt  = !w_last_k ? r_j : (w_last_j ? '0 : r_j + c_one);
    w_i_nxt  = !(w_last_k && w_last_j) ? r_i : (w_last_i ? '0 : r_i + c_one);
  end

  always_comb begin
    w_accept  = (r_state == S_IDLE) && start;
    w_advance = (r_state == S_ISSUE) && !w_last;
    w_addr_a_d = addr_A;
    w_addr_b_d = addr_B;
    if (w_accept) begin
      w_addr_a_d = '0;
      w_addr_b_d = '0;
    end else if (w_advance) begin
      w_addr_a_d = w_i_nxt * c_n + w_k_nxt;
      w_addr_b_d = w_k_nxt * c_p + w_j_nxt;
    end
    // Strobes trail the address by one cycle to line up with memory read data
    w_en_pp_d       = (r_state == S_ISSUE);
    w_en_mux_d      = w_en_pp_d && (r_k != '0);
    w_en_fd_d       = w_en_pp_d && w_last_k;
    w_addr_c_pipe_d = r_i * c_p + r_j;
    w_busy_d        = (w_next_state == S_ISSUE) || (w_next_state == S_DRAIN);
    w_done_d        = (w_next_state == S_DONE);
    w_error_d       = w_accept ? 1'b0 : (error | (writeEn_C & resultIsInvalid));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_i           <= '0;
      r_j           <= '0;
      r_k           <= '0;
      r_drain       <= 1'b0;
      r_addr_c_pipe <= '0;
      addr_A        <= '0;
      addr_B        <= '0;
      addr_C        <= '0;
      en_PPReg      <= 1'b0;
      en_Mux        <= 1'b0;
      en_FDReg      <= 1'b0;
      writeEn_C     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_i <= '0;
        r_j <= '0;
        r_k <= '0;
      end else if (r_state == S_ISSUE) begin
        r_i <= w_i_nxt;
        r_j <= w_j_nxt;
        r_k <= w_k_nxt;
      end
      r_drain       <= (r_state == S_DRAIN) && !r_drain;
      addr_A        <= w_addr_a_d;
      addr_B        <= w_addr_b_d;
      en_PPReg      <= w_en_pp_d;
      en_Mux        <= w_en_mux_d;
      en_FDReg      <= w_en_fd_d;
      r_addr_c_pipe <= w_addr_c_pipe_d;
      writeEn_C     <= en_FDReg;
      if (en_FDReg) addr_C <= r_addr_c_pipe;
      busy          <= w_busy_d;
      done          <= w_done_d;
      error         <= w_error_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mm_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mm_controller
// Purpose  : Self-checking bench for mm_controller with memory/data_path model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mm_controller;

  localparam int M   = 2;
  localparam int N   = 2;
  localparam int P   = 2;
  localparam int AW  = 8;
  localparam int MNP = M * N * P;

  logic          clk = 1'b0;
  logic          reset, start, resultIsInvalid;
  logic [AW-1:0] addr_A, addr_B, addr_C;
  logic          en_Mux, en_PPReg, en_FDReg, writeEn_C, busy, done, error;

  mm_controller #(.M(M), .N(N), .P(P), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .resultIsInvalid(resultIsInvalid),
    .addr_A(addr_A), .addr_B(addr_B), .en_Mux(en_Mux), .en_PPReg(en_PPReg),
    .en_FDReg(en_FDReg), .addr_C(addr_C), .writeEn_C(writeEn_C),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Synchronous-read memories and a behavioural data_path
  int mem_a [256];
  int mem_b [256];
  int rd_a = 0, rd_b = 0, pp = 0, fd = 0, sum;
  always_comb sum = (en_Mux ? pp : 0) + rd_a * rd_b;
  always @(posedge clk) begin
    rd_a <= mem_a[addr_A];
    rd_b <= mem_b[addr_B];
    if (en_PPReg) pp <= sum;
    if (en_FDReg) fd <= sum;
  end

  typedef struct {int addr; int data; int rel;} wr_t;
  wr_t exp_q[$];
  int  t0 = 0;
  bit  run_active = 1'b0;
  int  inv_rel = 0;

  always @(negedge clk) begin : mon
    int  rel, t;
    bit  pp_exp;
    wr_t e;
    rel = cyc - t0;
    if (writeEn_C) begin
      if (exp_q.size() == 0) check_val("unexpected_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        check_val("addr_C", 32'(addr_C), e.addr);
        check_val("data_C", fd, e.data);
        check_val("write_cycle", rel, e.rel);
      end
    end
    if (run_active) begin
      if (rel >= 1 && rel <= MNP) begin
        t = rel - 1;
        check_val("addr_A", 32'(addr_A), (t / (N * P)) * N + t % N);
        check_val("addr_B", 32'(addr_B), (t % N) * P + (t / N) % P);
      end
      t = rel - 2;
      pp_exp = (t >= 0) && (t < MNP);
      check_val("en_PPReg", 32'(en_PPReg), 32'(pp_exp));
      check_val("en_Mux",   32'(en_Mux),   32'(pp_exp && (t % N != 0)));
      check_val("en_FDReg", 32'(en_FDReg), 32'(pp_exp && (t % N == N - 1)));
      t = rel - 3;
      check_val("writeEn_C", 32'(writeEn_C), 32'((t >= 0) && (t < MNP) && (t % N == N - 1)));
      check_val("busy",  32'(busy),  32'((rel >= 1) && (rel <= MNP + 2)));
      check_val("done",  32'(done),  32'(rel == MNP + 3));
      check_val("error", 32'(error), 32'((inv_rel > 0) && (rel > inv_rel)));
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_addr_A"}, 32'(addr_A), 0);
    check_val({tag, "_addr_B"}, 32'(addr_B), 0);
    check_val({tag, "_addr_C"}, 32'(addr_C), 0);
    check_val({tag, "_strobes"}, 32'({en_Mux, en_PPReg, en_FDReg, writeEn_C}), 0);
    check_val({tag, "_status"}, 32'({busy, done, error}), 0);
  endtask

  // One run: start accepted at the next edge (cycle 0); cycle r = r-th interval after it
  task automatic run_mult(input int pulse_a, input int pulse_b, input int inv_at, input int abort_at);
    wr_t e;
    @(posedge clk); #1;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) begin
        e.addr = i * P + j;
        e.data = 0;
        for (int k = 0; k < N; k++) e.data += mem_a[i * N + k] * mem_b[k * P + j];
        e.rel = 3 + e.addr * N + N - 1;
        exp_q.push_back(e);
      end
    t0      = cyc;
    inv_rel = inv_at;
    start   = 1'b1;
    for (int r = 1; r <= MNP + 5; r++) begin
      @(posedge clk); #1;
      run_active      = 1'b1;
      start           = (r == pulse_a) || (r == pulse_b);
      resultIsInvalid = (r == inv_at);
      reset           = (r == abort_at);
      if (r == abort_at) begin
        @(posedge clk); #1;
        reset      = 1'b0;
        run_active = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_all_zero("abort");
        repeat (4) @(negedge clk);
        break;
      end
    end
    start           = 1'b0;
    resultIsInvalid = 1'b0;
    run_active      = 1'b0;
    check_val("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    reset           = 1'b1;
    start           = 1'b0;
    resultIsInvalid = 1'b0;
    for (int n = 0; n < 256; n++) begin
      mem_a[n] = 0;
      mem_b[n] = 0;
    end
    for (int n = 0; n < 4; n++) begin
      mem_a[n] = n + 1;
      mem_b[n] = n + 5;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    run_mult(0, 0, 0, 0);
    run_mult(3, MNP + 3, 0, 0);
    run_mult(0, 0, 6, 0);
    run_mult(0, 0, 0, 0);
    run_mult(0, 0, 0, 5);
    run_mult(0, 0, 0, 0);
    for (int n = 0; n < 4; n++) begin
      mem_a[n] = int'($urandom_range(0, 255));
      mem_b[n] = int'($urandom_range(0, 255));
    end
    run_mult(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mm_controller.md
Name: mm_controller

Overview:
- Sequencing controller that drives the `data_path` MAC datapath of the matrix multiplier.
- Computes C[M×P] = A[M×N] × B[N×P] with A, B and C stored row-major in synchronous-read memories.
- Generates the A/B read addresses and the datapath control strobes en_Mux, en_PPReg and en_FDReg.
- Generates the C write address and write enable, and reports completion and datapath errors through a start/busy/done handshake.

Parameters:
- M, 2, rows of A and C.
- N, 2, inner dimension: columns of A, rows of B; number of products per C element.
- P, 2, columns of B and C.
- ADDR_WIDTH, 8, width of all address outputs; must satisfy 2^ADDR_WIDTH ≥ max(M·N, N·P, M·P).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request one full multiplication; sampled only in IDLE.
- resultIsInvalid  input  1  error flag from data_path, qualified by writeEn_C.
- addr_A  output  ADDR_WIDTH  A read address, i·N+k.
- addr_B  output  ADDR_WIDTH  B read address, k·P+j.
- en_Mux  output  1  0 = load product, 1 = accumulate.
- en_PPReg  output  1  partial-product register enable.
- en_FDReg  output  1  final-data register enable.
- addr_C  output  ADDR_WIDTH  C write address, i·P+j.
- writeEn_C  output  1  C memory write strobe; writeData_C from data_path is valid this cycle.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle completion pulse.
- error  output  1  sticky; set if resultIsInvalid=1 on any writeEn_C cycle of the current run.

Behaviour:
- Memory and datapath contract:
  - A/B memories return data one cycle after the address is presented.
  - data_path updates its PP register on an en_PPReg cycle with the data present that cycle.
  - data_path updates its FD register on an en_FDReg cycle with the final sum; that sum appears on writeData_C the following cycle.
- Reset: all outputs 0, error cleared, counters i=j=k=0, state IDLE. Reset asserted mid-run aborts the run; no done, no further writes.
- State machine: IDLE → ISSUE → DRAIN → DONE → IDLE.
  - IDLE: start=1 → ISSUE; busy rises next cycle; error cleared on acceptance.
  - ISSUE: one (i,j,k) address pair per cycle, k fastest, then j, then i. After the address for (M-1,P-1,N-1) → DRAIN. Exactly M·P·N cycles.
  - DRAIN: two cycles, flushing the enable and write pipeline. Then → DONE.
  - DONE: done=1, busy=0 for one cycle, then → IDLE. start is ignored in DONE.
- Control pipeline, one stage behind address issue:
  - en_PPReg=1 on every data cycle.
  - en_Mux=0 on the data cycle of k=0; en_Mux=1 otherwise.
  - en_FDReg=1 on the data cycle of k=N-1.
  - en_PPReg, en_Mux and en_FDReg are 0 outside data cycles.
- Write stage, one cycle after en_FDReg: writeEn_C=1 with addr_C=i·P+j of that element.
- Throughput: one C element per N cycles; consecutive elements overlap with no bubbles.
- Timing from the start-accept edge at cycle 0:
  - addresses: cycles 1..MNP.
  - enables: cycles 2..MNP+1.
  - last write: cycle MNP+2.
  - done: cycle MNP+3.
- N=1: en_Mux stays 0; en_FDReg=1 on every data cycle.
- Outputs are registered. addr_A, addr_B and addr_C hold their last value when idle; the bench must not check them outside active cycles.
- Counters wrap to 0 at their bound; no address ever exceeds M·N-1, N·P-1 or M·P-1.
- start while busy: ignored; no restart, no queueing.
- error: OR of resultIsInvalid over all writeEn_C cycles; held until the next accepted start or reset.

Test Plan:
- Reset then start (M=N=P=2):
  - addr_A sequence 0,1,0,1,2,3,2,3; addr_B sequence 0,2,1,3,0,2,1,3 on cycles 1–8.
  - writeEn_C on cycles 4,6,8,10 with addr_C 0,1,2,3.
  - done on cycle 11.
- Enable pattern, same run:
  - en_Mux 0,1,0,1,0,1,0,1 on cycles 2–9.
  - en_FDReg=1 on cycles 3,5,7,9.
  - en_PPReg=1 on cycles 2–9 only.
- End-to-end with data_path and memories (A=[[1,2],[3,4]], B=[[5,6],[7,8]]): C written as 19,22,43,50.
- start pulsed on cycles 3 and 11 of a run: both ignored; exactly 4 writes; a single done.
- reset asserted at cycle 5: all outputs 0 at cycle 6; no writes after cycle 5. A new start then produces a full clean run.
- resultIsInvalid=1 on the write at cycle 6 only: error=1 from cycle 7 through done. The next start clears error.
